// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline widths, ALU encodings, decode-control bundle and its bubble value
package mips_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W = 3;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic [ALUCTRL_W-1:0] alu_control;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a D-stage source that needs the result of a load sitting in EX
// Ports: valid_i/mem_to_reg_i/rt_e_i describe the EX instruction, rs_d_i/rt_d_i are the
// D-stage sources, stall_o is the combinational stall request. $0 never matches.
module load_use_detect #(
  parameter int ADDR_W = 5
) (
  input  logic              valid_i,
  input  logic              mem_to_reg_i,
  input  logic [ADDR_W-1:0] rt_e_i,
  input  logic [ADDR_W-1:0] rs_d_i,
  input  logic [ADDR_W-1:0] rt_d_i,
  output logic              stall_o
);
  assign stall_o = valid_i & mem_to_reg_i & (rt_e_i != '0) & ((rt_e_i == rs_d_i) | (rt_e_i == rt_d_i));
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with stall, flush-to-bubble and load-use stall request
// Ports: CLK_IDEX/RST_IDEX (async active-low) clock and reset; StallE holds, FlushE loads a bubble
// (flush wins); *D inputs are captured into *E outputs; ValidE marks a real instruction;
// LoadUseStallD is combinational. Defining IDEX_BUBBLE_CNT_EN adds the saturating BubbleCount port.
import mips_pipe_pkg::*;
module id_ex_register #(
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
  parameter int ALUCTRL_W = mips_pipe_pkg::ALUCTRL_W
) (
  input  logic                  CLK_IDEX,
  input  logic                  RST_IDEX,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic [DATA_W-1:0]     RD1D,
  input  logic [DATA_W-1:0]     RD2D,
  input  logic [DATA_W-1:0]     SignImmD,
  input  logic [DATA_W-1:0]     PCPlus4D,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  output logic [DATA_W-1:0]     RD1E,
  output logic [DATA_W-1:0]     RD2E,
  output logic [DATA_W-1:0]     SignImmE,
  output logic [DATA_W-1:0]     PCPlus4E,
  output logic [REG_ADDR_W-1:0] RsE,
  output logic [REG_ADDR_W-1:0] RtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic                  ValidE,
  output logic                  LoadUseStallD
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]           BubbleCount
`endif
);
  localparam int PAY_W = 4*DATA_W + 3*REG_ADDR_W;
  localparam int W = PAY_W + $bits(ctrl_t) + 1;
  ctrl_t ctrl_in, ctrl_e;
  logic [W-1:0] e_d, e_q;
  assign ctrl_in = '{RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD};
  // whole E stage is one flat vector: {payload, controls, valid}
  assign e_d = FlushE ? {{PAY_W{1'b0}}, CTRL_BUBBLE, 1'b0}
             : StallE ? e_q
             : {RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD, ctrl_in, 1'b1};
  always_ff @(posedge CLK_IDEX or negedge RST_IDEX)
    if (!RST_IDEX) e_q <= '0;
    else e_q <= e_d;
  assign {RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE, ctrl_e, ValidE} = e_q;
  assign RegWriteE = ctrl_e.reg_write;
  assign MemtoRegE = ctrl_e.mem_to_reg;
  assign MemWriteE = ctrl_e.mem_write;
  assign ALUSrcE = ctrl_e.alu_src;
  assign RegDstE = ctrl_e.reg_dst;
  assign ALUControlE = ctrl_e.alu_control;
  load_use_detect #(.ADDR_W(REG_ADDR_W)) u_lud (
    .valid_i(ValidE),
    .mem_to_reg_i(MemtoRegE),
    .rt_e_i(RtE),
    .rs_d_i(RsD),
    .rt_d_i(RtD),
    .stall_o(LoadUseStallD)
  );
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bub_d, bub_q;
  assign bub_d = (FlushE && bub_q != '1) ? bub_q + 32'd1 : bub_q;
  always_ff @(posedge CLK_IDEX or negedge RST_IDEX)
    if (!RST_IDEX) bub_q <= '0;
    else bub_q <= bub_d;
  assign BubbleCount = bub_q;
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed and random checks of id_ex_register against a transaction-level model
module tb_id_ex_register;
  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0] rs, rt, rd;
    logic rw, mtr, mw, as, rdst;
    logic [2:0] alu;
    logic v;
  } st_t;
  logic clk = 0, rst_n = 0, stall = 0, flush = 0;
  st_t inp = '0, m = '0;
  logic [31:0] bc = 0;
  int checks = 0, failures = 0;
  logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;
  logic [4:0] RsE, RtE, RdE;
  logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE, LoadUseStallD;
  logic [2:0] ALUControlE;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] BubbleCount;
`endif
  always #5 clk = ~clk;
  id_ex_register dut (
    .CLK_IDEX(clk), .RST_IDEX(rst_n), .StallE(stall), .FlushE(flush),
    .RD1D(inp.rd1), .RD2D(inp.rd2), .SignImmD(inp.imm), .PCPlus4D(inp.pc4),
    .RsD(inp.rs), .RtD(inp.rt), .RdD(inp.rd),
    .RegWriteD(inp.rw), .MemtoRegD(inp.mtr), .MemWriteD(inp.mw), .ALUSrcD(inp.as), .RegDstD(inp.rdst),
    .ALUControlD(inp.alu),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .ALUControlE(ALUControlE), .ValidE(ValidE), .LoadUseStallD(LoadUseStallD)
`ifdef IDEX_BUBBLE_CNT_EN
    , .BubbleCount(BubbleCount)
`endif
  );
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic st_t act();
    return '{RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE,
             RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE};
  endfunction
  function automatic logic exp_lu();
    return m.v && m.mtr && m.rt != 0 && (m.rt == inp.rs || m.rt == inp.rt);
  endfunction
  task automatic check_model(input string tag);
    chk(tag, act(), m);
    chk({tag, "_lu"}, LoadUseStallD, exp_lu());
`ifdef IDEX_BUBBLE_CNT_EN
    chk({tag, "_bc"}, BubbleCount, bc);
`endif
  endtask
  task automatic step();
    @(posedge clk);
    if (flush) begin
      m = '0;
      if (bc != 32'hFFFF_FFFF) bc = bc + 1;
    end else if (!stall) begin
      m = inp;
      m.v = 1'b1;
    end
    #1;
  endtask
  initial begin
    #12;
    check_model("reset");
    @(negedge clk) rst_n = 1;
    inp = '0;
    inp.rd1 = 32'hA5A5_0001; inp.rt = 9; inp.rw = 1; inp.alu = 3'b010;
    step();
    check_model("load");
    chk("load_rd1", RD1E, 32'hA5A5_0001);
    chk("load_rt", RtE, 9);
    chk("load_rw", RegWriteE, 1);
    chk("load_valid", ValidE, 1);
    inp.rd2 = 32'h55;
    step();
    stall = 1; inp.rd2 = 32'hFF;
    repeat (3) step();
    chk("stall_rd2", RD2E, 32'h55);
    check_model("stall");
    stall = 0;
    step();
    chk("release_rd2", RD2E, 32'hFF);
    inp.rw = 1;
    step();
    flush = 1; stall = 1;
    step();
    chk("flush_rw", RegWriteE, 0);
    chk("flush_valid", ValidE, 0);
    check_model("flush_stall");
    flush = 0; stall = 0;
    inp = '0; inp.rt = 8; inp.mtr = 1;
    step();
    inp.rs = 8; inp.rt = 3; #1;
    chk("lu_hit", LoadUseStallD, 1);
    check_model("lu_hit_m");
    inp.rs = 0; inp.rt = 0; inp.mtr = 1;
    step();
    inp.rs = 8; #1;
    chk("lu_rt0", LoadUseStallD, 0);
    flush = 1;
    step();
    flush = 0; inp.rs = 8; inp.rt = 8; #1;
    chk("lu_invalid", LoadUseStallD, 0);
    inp = '0; inp.rs = 5;
    @(negedge clk) inp.rd1 = 32'hDEAD;
    step();
    chk("wb_rd1", RD1E, 32'hDEAD);
    inp.rd1 = 32'h1234;
    step();
    @(negedge clk) #2 rst_n = 0;
    #1 m = '0; bc = 0;
    chk("async_rd1", RD1E, 0);
    check_model("async_rst");
    @(posedge clk) #1;
    check_model("rst_held");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      inp = st_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      inp.rs = 5'($urandom_range(0, 3));
      inp.rt = 5'($urandom_range(0, 3));
      inp.v = 0;
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_lu_pre", LoadUseStallD, exp_lu());
      step();
      check_model("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures both read-data words, the sign-extended immediate, register specifiers and decode controls at each rising edge, and presents them to the EX stage.
- Supports hold (stall) and bubble insertion (flush).
- Generates the load-use stall request from the instruction currently held in EX.

Parameters:
DATA_W, 32, width of read data, immediate and PC+4
REG_ADDR_W, 5, register specifier width
ALUCTRL_W, 3, ALU control field width

Ports:
CLK_IDEX  in  1  pipeline clock, rising-edge active
RST_IDEX  in  1  asynchronous, active-low reset
StallE  in  1  hold all E-stage contents
FlushE  in  1  load a bubble
RD1D, RD2D  in  DATA_W  register file read ports 1/2
SignImmD  in  DATA_W  sign-extended immediate
PCPlus4D  in  DATA_W  decode-stage PC+4
RsD, RtD, RdD  in  REG_ADDR_W  instruction register fields
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode controls
ALUControlD  in  ALUCTRL_W  ALU operation
RD1E, RD2E, SignImmE, PCPlus4E  out  DATA_W  registered data
RsE, RtE, RdE  out  REG_ADDR_W  registered specifiers
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls
ALUControlE  out  ALUCTRL_W  registered ALU operation
ValidE  out  1  E stage holds a real instruction
LoadUseStallD  out  1  combinational stall request to IF/ID
BubbleCount  out  32  present only with the optional feature

Behaviour:
- Reset (RST_IDEX low, asynchronous): every registered output is 0, including ValidE; BubbleCount is 0. Outputs stay 0 while reset is held.
- The register file writes on the falling edge, so RD1D/RD2D already reflect a same-cycle writeback at the rising edge. No internal bypass is provided.
- Rising-edge priority: FlushE > StallE > load.
  - FlushE=1: load a bubble. All control outputs, data and specifiers become 0; ValidE becomes 0.
  - FlushE=0, StallE=1: all outputs hold their previous values, including ValidE.
  - FlushE=0, StallE=0: capture every D input into E; ValidE becomes 1.
- Latency: one cycle from D inputs to E outputs. Throughput is one instruction per cycle when not stalled.
- LoadUseStallD = ValidE & MemtoRegE & (RtE != 0) & ((RtE == RsD) | (RtE == RtD)).
  - Purely combinational; it does not depend on StallE or FlushE.
  - The hazard unit drives FlushE=1 in the cycle LoadUseStallD=1, so the dependent instruction is held in IF/ID and a bubble enters EX.
- Simultaneous FlushE and StallE: the flush wins.
- Reset deasserted mid-pipeline: the first rising edge after release behaves as a normal edge under the priority rules above.
- Register $0: RsD/RtD equal to 0 never raises LoadUseStallD.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- Defined:
  - BubbleCount port and 32-bit counter are present.
  - Counter increments on every rising edge where FlushE=1, including edges where StallE is also 1.
  - Counter saturates at 32'hFFFF_FFFF.
  - Counter is cleared only by reset.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - DATA_W, REG_ADDR_W, ALUCTRL_W constants
  - ALU control encodings
  - a packed control-bundle typedef (RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl)
  - the zero-bubble constant of that typedef
- One sub-module is natural: load_use_detect. It contains the comparator logic only and is reused by a future EX/MEM hazard unit.

Test Plan:
- Reset mid-run: assert RST_IDEX low asynchronously between edges with RD1D=32'h1234 loaded -> every output reads 0 immediately, before the next edge; BubbleCount=0.
- Normal load: RD1D=32'hA5A5_0001, RtD=9, RegWriteD=1, ALUControlD=3'b010, stall/flush 0 -> after one edge RD1E=32'hA5A5_0001, RtE=9, RegWriteE=1, ValidE=1.
- Stall hold: load RD2D=32'h55, then StallE=1 for 3 edges while RD2D=32'hFF -> RD2E stays 32'h55; after release RD2E=32'hFF one edge later.
- Flush priority: FlushE=1 and StallE=1 together with RegWriteE=1 held -> next edge gives all controls 0, ValidE=0; BubbleCount increments by 1 when the feature is enabled.
- Load-use: E holds lw with RtE=8, MemtoRegE=1, ValidE=1; RsD=8 -> LoadUseStallD=1. With RsD=8 but RtE=0 -> 0. With ValidE=0 -> 0.
- Writeback same cycle: register file writes $5=32'hDEAD on the falling edge; RsD=5 -> RD1E=32'hDEAD after the next rising edge.
